// File: rtl/timer_bus_responder.sv
// ---------------------------------------------------------------------------
// timer_bus_responder
//
// A timer peripheral that software programs over the CPU data bus. Software
// sets a prescale select, a compare value and the count, and reads a
// match-pending status. When the count matches the compare value, the timer
// emits a one-cycle match pulse and can raise a level interrupt to the core.
//
// Register map (word offsets; unused bits read as 0):
//   0x0 CTRL   : [0] EN, [1] IRQ_EN, [2] ONESHOT, [7:4] PSEL     (R/W)
//   0x4 CMP    : [CNT_W-1:0]                                     (R/W)
//   0x8 COUNT  : [CNT_W-1:0]  read = live count, write = load
//   0xC STATUS : [0] MATCH (write 1 to clear), [1] RUNNING = EN  (RO)
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   req          bus request, held high by the master until ack
//   we           1 = write, 0 = read
//   addr         byte offset within the block (addr[1:0] ignored)
//   wdata        write data
//   rdata        read data, valid while ack = 1, otherwise 0
//   ack          one-cycle transfer acknowledge
//   irq          registered STATUS.MATCH & CTRL.IRQ_EN
//   match_pulse  one-cycle pulse on every compare match
// ---------------------------------------------------------------------------
module timer_bus_responder #(
    parameter int          CNT_W      = 16,
    parameter int unsigned PSEL_RESET = 15,
    parameter int unsigned CMP_RESET  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        irq,
    output logic        match_pulse
);

    // Register state
    logic             en_q,       en_d;
    logic             irqEn_q,    irqEn_d;
    logic             oneShot_q,  oneShot_d;
    logic [3:0]       psel_q,     psel_d;
    logic [CNT_W-1:0] cmp_q,      cmp_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [15:0]      presc_q,    presc_d;
    logic             match_q,    match_d;
    logic             ack_q,      ack_d;
    logic [31:0]      rdata_q,    rdata_d;
    logic             irq_q,      irq_d;
    logic             matchPulse_q, matchPulse_d;

    // Decode helpers
    logic        accept;
    logic        wrCtrl, wrCmp, wrCount, wrStatus;
    logic        rdEn;
    logic [1:0]  wordSel;
    logic [31:0] readData;
    logic [15:0] pscLimit;
    logic        tick;
    logic        isMatch;
    logic        unused_bits;

    // A request is only taken while no ack is outstanding, so a master that
    // keeps req high during its ack cycle does not start a second transfer.
    assign accept   = req & ~ack_q;
    assign wordSel  = addr[3:2];
    assign rdEn     = accept & ~we;
    assign wrCtrl   = accept & we & (wordSel == 2'd0);
    assign wrCmp    = accept & we & (wordSel == 2'd1);
    assign wrCount  = accept & we & (wordSel == 2'd2);
    assign wrStatus = accept & we & (wordSel == 2'd3);

    // Byte-lane bits and high data bits carry no meaning for this block.
    assign unused_bits = &{1'b0, addr[1:0], wdata[31:CNT_W]};

    // The prescaler wraps after 2^PSEL clocks; PSEL = 0 ticks on every clock.
    assign pscLimit = 16'((32'd1 << psel_q) - 32'd1);
    assign tick     = en_q & (presc_q == pscLimit);

    // A software load of COUNT on a tick edge takes priority, so no compare
    // is evaluated on that edge.
    assign isMatch  = tick & ~wrCount & (count_q == cmp_q);

    // Register read mux, reflecting register values before the sampling edge
    always_comb begin
        readData = '0;
        case (wordSel)
            2'd0:    readData = {24'd0, psel_q, 1'b0, oneShot_q, irqEn_q, en_q};
            2'd1:    readData[CNT_W-1:0] = cmp_q;
            2'd2:    readData[CNT_W-1:0] = count_q;
            default: readData = {30'd0, en_q, match_q};
        endcase
    end

    // Next-state logic for the bus handshake, registers and timer
    always_comb begin
        en_d         = en_q;
        irqEn_d      = irqEn_q;
        oneShot_d    = oneShot_q;
        psel_d       = psel_q;
        cmp_d        = cmp_q;
        count_d      = count_q;
        presc_d      = presc_q;
        match_d      = match_q;
        ack_d        = accept;
        rdata_d      = rdEn ? readData : 32'd0;
        irq_d        = match_q & irqEn_q;
        matchPulse_d = isMatch;

        if (wrCtrl) begin
            en_d      = wdata[0];
            irqEn_d   = wdata[1];
            oneShot_d = wdata[2];
            psel_d    = wdata[7:4];
        end
        if (wrCmp) begin
            cmp_d = wdata[CNT_W-1:0];
        end

        // Prescaler restarts on any CTRL write so a new PSEL starts cleanly
        if (wrCtrl || !en_q || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 16'd1;
        end

        if (wrCount) begin
            count_d = wdata[CNT_W-1:0];
        end else if (tick) begin
            if (count_q == cmp_q) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        // A new match beats a same-edge clear so no event is lost
        if (isMatch) begin
            match_d = 1'b1;
        end else if (wrStatus && wdata[0]) begin
            match_d = 1'b0;
        end

        if (isMatch && oneShot_q) begin
            en_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q         <= 1'b0;
            irqEn_q      <= 1'b0;
            oneShot_q    <= 1'b0;
            psel_q       <= 4'(PSEL_RESET);
            cmp_q        <= CNT_W'(CMP_RESET);
            count_q      <= '0;
            presc_q      <= '0;
            match_q      <= 1'b0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
            irq_q        <= 1'b0;
            matchPulse_q <= 1'b0;
        end else begin
            en_q         <= en_d;
            irqEn_q      <= irqEn_d;
            oneShot_q    <= oneShot_d;
            psel_q       <= psel_d;
            cmp_q        <= cmp_d;
            count_q      <= count_d;
            presc_q      <= presc_d;
            match_q      <= match_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            irq_q        <= irq_d;
            matchPulse_q <= matchPulse_d;
        end
    end

    assign rdata       = rdata_q;
    assign ack         = ack_q;
    assign irq         = irq_q;
    assign match_pulse = matchPulse_q;

endmodule
